// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: loader FSM states, the frame sync
// byte and the RAM address-width derivation.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        RUN,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int unsigned addr_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: double-flopped input, falling-edge start detect, mid-bit sampling,
// one-cycle byte strobe (LSB first) or one-cycle framing-error strobe.
module uart_rx_8n1 #(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       pclk,
    input  logic       RESET,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned DIV       = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned START_CNT = (DIV / 2 > 0) ? DIV / 2 - 1 : 0;
    localparam int unsigned CNT_W     = $clog2(DIV + 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             sync1_q, sync2_q, prev_q;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge pclk or negedge RESET) begin
        if (!RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = CNT_W'(START_CNT);
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    // A high line at mid start bit was a glitch, not a start bit.
                    if (!sync2_q) begin
                        state_d = RX_DATA;
                        cnt_d   = CNT_W'(DIV - 1);
                        bit_d   = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = CNT_W'(DIV - 1);
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte    = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: holds the CPU in reset, receives a checksummed frame over UART
// into RAM through a muxed RAM port, then releases the CPU.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter  int unsigned CLK_HZ    = 12000000,
    parameter  int unsigned BAUD      = 115200,
    parameter  int unsigned RAM_WORDS = 1536,
    parameter  int unsigned BOOT_WAIT = 12000000,
    parameter  int unsigned BYTE_TMO  = 120000,
    localparam int unsigned ADDR_W    = addr_width(RAM_WORDS)
) (
    input  logic              pclk,
    input  logic              RESET,
    input  logic              RXD,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [31:0]       cpu_mem_wdata,
    input  logic [3:0]        cpu_mem_wmask,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wmask,
    output logic              cpu_reset_n,
    output logic              loading,
    output logic              done,
    output logic              error
);

    localparam int unsigned BOOT_W = $clog2(BOOT_WAIT + 1);
    localparam int unsigned TMO_W  = $clog2(BYTE_TMO + 1);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    uart_rx_8n1 #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .pclk       (pclk),
        .RESET      (RESET),
        .rxd        (RXD),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [BOOT_W-1:0] boot_q, boot_d;
    logic              boot_en_q, boot_en_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              error_q, error_d;

    logic [15:0] new_len;
    logic [31:0] word_next;
    logic        tmo_hit;

    always_ff @(posedge pclk or negedge RESET) begin
        if (!RESET) begin
            state_q   <= WAIT_SYNC;
            len_q     <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            bcnt_q    <= '0;
            csum_q    <= '0;
            tmo_q     <= '0;
            boot_q    <= '0;
            boot_en_q <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            bcnt_q    <= bcnt_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            boot_q    <= boot_d;
            boot_en_q <= boot_en_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            error_q   <= error_d;
        end
    end

    assign loading   = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA) || (state_q == CSUM);
    assign new_len   = {rx_byte, len_q[7:0]};
    assign word_next = {rx_byte, word_q[31:8]};
    assign tmo_hit   = (tmo_q == TMO_W'(BYTE_TMO - 1));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        word_d    = word_q;
        bcnt_d    = bcnt_q;
        csum_d    = csum_q;
        boot_d    = boot_q;
        boot_en_d = boot_en_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        error_d   = error_q;
        // Idle timer only runs inside a frame; any received byte restarts it.
        if (loading && !byte_valid) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = '0;
        end

        unique case (state_q)
            WAIT_SYNC: begin
                if (boot_en_q) begin
                    boot_d = boot_q + 1'b1;
                end
                if (byte_valid && rx_byte == SYNC_BYTE) begin
                    state_d   = LEN_LO;
                    error_d   = 1'b0;
                    boot_en_d = 1'b0;
                end else if (boot_en_q && boot_q == BOOT_W'(BOOT_WAIT - 1)) begin
                    state_d = RUN;
                end
            end
            LEN_LO: begin
                if (byte_valid) begin
                    len_d[7:0] = rx_byte;
                    state_d    = LEN_HI;
                end else if (frame_err || tmo_hit) begin
                    state_d = ERR;
                end
            end
            LEN_HI: begin
                if (byte_valid) begin
                    len_d = new_len;
                    if (new_len == 16'd0 || 32'(new_len) > RAM_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                        bcnt_d  = '0;
                        csum_d  = '0;
                    end
                end else if (frame_err || tmo_hit) begin
                    state_d = ERR;
                end
            end
            DATA: begin
                if (byte_valid) begin
                    word_d = word_next;
                    csum_d = csum_q + rx_byte;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q;
                        wr_data_d = word_next;
                        idx_d     = idx_q + 1'b1;
                        if (32'(idx_q) == 32'(len_q) - 32'd1) begin
                            state_d = CSUM;
                        end
                    end
                end else if (frame_err || tmo_hit) begin
                    state_d = ERR;
                end
            end
            CSUM: begin
                if (byte_valid) begin
                    state_d = (rx_byte == csum_q) ? RUN : ERR;
                end else if (frame_err || tmo_hit) begin
                    state_d = ERR;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            ERR: begin
                error_d = 1'b1;
                state_d = WAIT_SYNC;
            end
            default: state_d = WAIT_SYNC;
        endcase
    end

    always_comb begin
        ram_addr  = cpu_mem_addr;
        ram_wdata = cpu_mem_wdata;
        ram_wmask = cpu_mem_wmask;
        if (loading) begin
            ram_addr  = wr_addr_q;
            ram_wdata = wr_data_q;
            ram_wmask = wr_en_q ? 4'hF : 4'h0;
        end
    end

    assign cpu_reset_n = (state_q == RUN);
    assign done        = (state_q == RUN);
    assign error       = error_q;

endmodule
